// File: rtl/sub_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sub_div_ctrl (with helper Nbit_Subtracter)
//  Description : Unsigned restoring divider controller. One quotient bit is
//                resolved per clock through a single shared n+1 bit ripple
//                subtracter. IDLE -> CALC (n cycles) -> DONE (1 cycle) -> IDLE.
//                Optional macro SUB_DIV_CTRL_DIV0_EN short-circuits a zero
//                divisor straight from IDLE to DONE and flags div_by_zero.
//  Revision    : 1.0 - initial release
// ============================================================================

// Ripple-borrow subtracter: o_diff = i_a - i_b - i_b_in, o_b_out = borrow.
module Nbit_Subtracter #(
    parameter int W = 9
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_b_in,
    output logic [W-1:0] o_diff,
    output logic         o_b_out
);

    logic [W:0] w_bor;

    assign w_bor[0] = i_b_in;

    generate
        for (genvar k = 0; k < W; k++) begin : g_bit
            // Full subtracter cell; borrow ripples towards the MSB.
            assign o_diff[k]    = i_a[k] ^ i_b[k] ^ w_bor[k];
            assign w_bor[k + 1] = (~i_a[k] & i_b[k]) | (~(i_a[k] ^ i_b[k]) & w_bor[k]);
        end
    endgenerate

    assign o_b_out = w_bor[W];

endmodule

module sub_div_ctrl #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         div_by_zero
);

    localparam int        c_CW   = $clog2(n + 1);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(n - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [n-1:0]    r_dvd;      // dividend, shifted left so the next bit is the MSB
    logic [n-1:0]    r_dvs;      // captured divisor
    logic [n-1:0]    r_rem;      // partial remainder
    logic [n-1:0]    r_quo_w;    // quotient under construction
    logic [c_CW-1:0] r_cnt;
    logic [n-1:0]    r_quotient;
    logic [n-1:0]    r_remainder;

    logic            w_accept;
    logic            w_last;
    logic [n:0]      w_trial;
    logic [n:0]      w_sub_b;
    logic [n:0]      w_diff;
    logic            w_borrow;
    logic            w_take;
    logic [n-1:0]    w_rem_next;
    logic [n-1:0]    w_quo_next;
    logic            w_div0;

    assign w_accept = (r_state == c_IDLE) && start;
    assign w_last   = (r_cnt == c_LAST);
    assign w_trial  = {r_rem, r_dvd[n-1]};
    assign w_sub_b  = {1'b0, r_dvs};

    Nbit_Subtracter #(
        .W (n + 1)
    ) u_sub (
        .i_a     (w_trial),
        .i_b     (w_sub_b),
        .i_b_in  (1'b0),
        .o_diff  (w_diff),
        .o_b_out (w_borrow)
    );

    // Without a borrow the difference is below the divisor, so its top bit
    // is always clear; including it keeps every subtracter output in use.
    assign w_take     = ~w_borrow & ~w_diff[n];
    assign w_rem_next = w_take ? w_diff[n-1:0] : w_trial[n-1:0];
    assign w_quo_next = {r_quo_w[n-2:0], w_take};

`ifdef SUB_DIV_CTRL_DIV0_EN
    logic r_div0;
    assign w_div0 = (divisor == '0);
`else
    assign w_div0 = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; start only matters in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_next_state = w_div0 ? c_DONE : c_CALC;
                end
            end
            c_CALC: begin
                if (w_last) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Datapath: operand capture, per-cycle restoring step, result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_quo_w     <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (w_accept) begin
            r_dvd   <= dividend;
            r_dvs   <= divisor;
            r_rem   <= '0;
            r_quo_w <= '0;
            r_cnt   <= '0;
            if (w_div0) begin
                r_quotient  <= '1;
                r_remainder <= dividend;
            end
        end else if (r_state == c_CALC) begin
            r_dvd   <= {r_dvd[n-2:0], 1'b0};
            r_rem   <= w_rem_next;
            r_quo_w <= w_quo_next;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_quotient  <= w_quo_next;
                r_remainder <= w_rem_next;
            end
        end
    end

`ifdef SUB_DIV_CTRL_DIV0_EN
    // Zero-divisor flag, latched on acceptance and shown alongside done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div0 <= 1'b0;
        end else if (w_accept) begin
            r_div0 <= w_div0;
        end
    end
`endif

    // Output decode from state.
    always_comb begin
        busy        = (r_state == c_CALC);
        done        = (r_state == c_DONE);
`ifdef SUB_DIV_CTRL_DIV0_EN
        div_by_zero = (r_state == c_DONE) && r_div0;
`else
        div_by_zero = 1'b0;
`endif
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule
`default_nettype wire
